// File: rtl/sdram_test_master_if.sv
// sdram_test_master_if
//   Request/acknowledge port between the SDRAM test master (initiator) and
//   the SDRAM controller (responder). Signal names keep the initiator's view:
//   o* are driven by the test master, i* are driven by the controller.
//   owrite_req / owrite_address / owrite_data : write request, held until ack
//   iwrite_ack                                 : one-cycle write completion
//   oread_req / oread_address                  : read request, held until ack
//   iread_data / iread_ack                     : read data valid with ack pulse
interface sdram_test_master_if;
  logic        owrite_req;
  logic [24:0] owrite_address;
  logic [15:0] owrite_data;
  logic        iwrite_ack;
  logic        oread_req;
  logic [24:0] oread_address;
  logic [15:0] iread_data;
  logic        iread_ack;

  modport master (
    output owrite_req, owrite_address, owrite_data, oread_req, oread_address,
    input  iwrite_ack, iread_data, iread_ack
  );

  modport slave (
    input  owrite_req, owrite_address, owrite_data, oread_req, oread_address,
    output iwrite_ack, iread_data, iread_ack
  );
endinterface

// File: rtl/sdram_test_master.sv
// sdram_test_master
//   Bring-up / soak initiator for the SDRAM controller. On istart it writes
//   data = addr[15:0] ^ seed over [base, base+length) (25-bit wrapping
//   addresses), reads the range back and compares every word. Reports
//   pass/fail, a saturating mismatch count and the first failing word, and
//   aborts if an acknowledge takes TIMEOUT cycles.
// Ports
//   iclk, ireset_n         : clock, asynchronous active-low reset
//   istart                 : one-cycle start pulse, honoured only when idle
//   ibase_address, ilength : first word address, number of words (0 legal)
//   iseed                  : pattern seed
//   obusy, odone           : run in progress, one-cycle completion pulse
//   opass, otimeout        : result flags, valid until the next start
//   oerr_count             : mismatch count (saturates at 0xFFFF)
//   oerr_address/expected/got : first mismatch details
//   bus                    : controller request/acknowledge port (master side)
module sdram_test_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        istart,
  input  logic [24:0] ibase_address,
  input  logic [24:0] ilength,
  input  logic [15:0] iseed,
  output logic        obusy,
  output logic        odone,
  output logic        opass,
  output logic        otimeout,
  output logic [15:0] oerr_count,
  output logic [24:0] oerr_address,
  output logic [15:0] oerr_expected,
  output logic [15:0] oerr_got,
  sdram_test_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH
  } state_t;

  // Watchdog expires on the edge that would make it reach TIMEOUT.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [24:0] base_q, len_q, idx;
  logic [15:0] seed_q, wdog;
  logic        wdog_expired, more_words, rd_mismatch;
  logic [24:0] next_addr;
  logic        write_req_d, read_req_d, busy_d, done_d;

  always_comb begin
    wdog_expired = (wdog == WDOG_LAST);
    more_words   = (idx < len_q);
    next_addr    = base_q + idx;
    rd_mismatch  = (bus.iread_data != (bus.oread_address[15:0] ^ seed_q));
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) state <= IDLE;
    else           state <= state_next;
  end

  // An acknowledge takes priority over a watchdog expiring in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (istart) state_next = (ilength != '0) ? WR_REQ : FINISH;
      WR_REQ:  if (bus.iwrite_ack) state_next = WR_GAP;
               else if (wdog_expired) state_next = FINISH;
      WR_GAP:  state_next = more_words ? WR_REQ : RD_REQ;
      RD_REQ:  if (bus.iread_ack) state_next = RD_GAP;
               else if (wdog_expired) state_next = FINISH;
      RD_GAP:  state_next = more_words ? RD_REQ : FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  // obusy is held through the odone cycle and falls with it.
  always_comb begin
    write_req_d = (state_next == WR_REQ);
    read_req_d  = (state_next == RD_REQ);
    done_d      = (state == FINISH);
    busy_d      = (state_next != IDLE) || (state == FINISH);
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      obusy              <= 1'b0;
      odone              <= 1'b0;
      opass              <= 1'b0;
      otimeout           <= 1'b0;
      oerr_count         <= '0;
      oerr_address       <= '0;
      oerr_expected      <= '0;
      oerr_got           <= '0;
      bus.owrite_req     <= 1'b0;
      bus.owrite_address <= '0;
      bus.owrite_data    <= '0;
      bus.oread_req      <= 1'b0;
      bus.oread_address  <= '0;
      base_q             <= '0;
      len_q              <= '0;
      seed_q             <= '0;
      idx                <= '0;
      wdog               <= '0;
    end else begin
      obusy         <= busy_d;
      odone         <= done_d;
      bus.owrite_req <= write_req_d;
      bus.oread_req  <= read_req_d;

      if ((state == WR_REQ) || (state == RD_REQ)) wdog <= wdog + 16'd1;
      else                                        wdog <= '0;

      case (state)
        IDLE: if (istart) begin
          base_q             <= ibase_address;
          len_q              <= ilength;
          seed_q             <= iseed;
          idx                <= '0;
          bus.owrite_address <= ibase_address;
          bus.owrite_data    <= ibase_address[15:0] ^ iseed;
          opass              <= 1'b0;
          otimeout           <= 1'b0;
          oerr_count         <= '0;
          oerr_address       <= '0;
          oerr_expected      <= '0;
          oerr_got           <= '0;
        end
        WR_REQ: begin
          if (bus.iwrite_ack)    idx      <= idx + 25'd1;
          else if (wdog_expired) otimeout <= 1'b1;
        end
        // Next request's address/data are loaded during the gap so they are
        // already stable when the request rises.
        WR_GAP: begin
          if (more_words) begin
            bus.owrite_address <= next_addr;
            bus.owrite_data    <= next_addr[15:0] ^ seed_q;
          end else begin
            idx               <= '0;
            bus.oread_address <= base_q;
          end
        end
        RD_REQ: begin
          if (bus.iread_ack) begin
            idx <= idx + 25'd1;
            if (rd_mismatch) begin
              if (oerr_count == '0) begin
                oerr_address  <= bus.oread_address;
                oerr_expected <= bus.oread_address[15:0] ^ seed_q;
                oerr_got      <= bus.iread_data;
              end
              if (oerr_count != '1) oerr_count <= oerr_count + 16'd1;
            end
          end else if (wdog_expired) begin
            otimeout <= 1'b1;
          end
        end
        RD_GAP: if (more_words) bus.oread_address <= next_addr;
        FINISH: opass <= (oerr_count == '0) && !otimeout;
        default: ;
      endcase
    end
  end

endmodule
